// File: rtl/npu_seq_pkg.sv
// Shared constants and state type for the NPU instruction sequencer.
// Constant values match the NPU opcode defines.
package npu_seq_pkg;

    localparam int unsigned OPCODE_WIDTH     = 4;
    localparam int unsigned INSTR_WIDTH      = 46;
    localparam int unsigned INSTR_MEM_AWIDTH = 10;
    localparam int unsigned END_CHAIN_OP     = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/instr_mem_sdp.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module instr_mem_sdp #(
    parameter int unsigned DATA_WIDTH = 46,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/npu_instr_sequencer.sv
// Instruction-memory front end for the NPU: host preload, 1-cycle fetch service,
// END_CHAIN substitution/detection, completion pulse and fetch statistics.
module npu_instr_sequencer #(
    parameter int unsigned OPCODE_WIDTH     = npu_seq_pkg::OPCODE_WIDTH,
    parameter int unsigned INSTR_WIDTH      = npu_seq_pkg::INSTR_WIDTH,
    parameter int unsigned INSTR_MEM_AWIDTH = npu_seq_pkg::INSTR_MEM_AWIDTH,
    parameter int unsigned END_CHAIN_OP     = npu_seq_pkg::END_CHAIN_OP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_valid,
    input  logic [INSTR_MEM_AWIDTH-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]      load_data,
    input  logic                        start,
    input  logic [INSTR_MEM_AWIDTH:0]   prog_len,
    input  logic                        get_instr,
    input  logic [INSTR_MEM_AWIDTH-1:0] get_instr_addr,
    output logic [INSTR_WIDTH-1:0]      instruction,
    output logic                        instr_valid,
    output logic                        busy,
    output logic                        done,
    output logic [INSTR_MEM_AWIDTH:0]   fetch_count,
    output logic                        load_err
);

    import npu_seq_pkg::*;

    localparam int unsigned             CW       = INSTR_MEM_AWIDTH + 1;
    localparam logic [OPCODE_WIDTH-1:0] END_OP   = OPCODE_WIDTH'(END_CHAIN_OP);
    localparam logic [INSTR_WIDTH-1:0]  END_WORD = {END_OP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

    // The RAM read register cannot be reset, so the output word is selected
    // after it: zero after reset, RAM data, or the substituted END_CHAIN word.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_END  = 2'd2
    } out_sel_e;

    seq_state_e             state_q, state_d;
    out_sel_e               sel_q, sel_d;
    logic [CW-1:0]          plen_q, plen_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [INSTR_WIDTH-1:0] rdata;
    logic                   end_seen;
    logic                   fetch_ok;
    logic                   mem_we;

    instr_mem_sdp #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (INSTR_MEM_AWIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (fetch_ok),
        .raddr_i (get_instr_addr),
        .rdata_o (rdata)
    );

    always_comb begin
        unique case (sel_q)
            SEL_MEM: instruction = rdata;
            SEL_END: instruction = END_WORD;
            default: instruction = '0;
        endcase
    end

    always_comb begin
        end_seen = (state_q == RUN) && valid_q
                   && (instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH] == END_OP);
        fetch_ok = (state_q == RUN) && get_instr && !end_seen;
        mem_we   = load_valid && (state_q != RUN);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        plen_d  = plen_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        valid_d = fetch_ok;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    plen_d  = prog_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (load_valid) begin
                    err_d = 1'b1;
                end
                if (end_seen) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fetch_ok) begin
            sel_d = ({1'b0, get_instr_addr} < plen_q) ? SEL_MEM : SEL_END;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_ZERO;
            plen_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign instr_valid = valid_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign fetch_count = cnt_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_npu_instr_sequencer.sv
// Directed bench for npu_instr_sequencer with a cycle-level behavioural model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_npu_instr_sequencer;

    localparam int OW = 4;
    localparam int IW = 46;
    localparam int AW = 10;
    localparam int CW = AW + 1;

    localparam logic [IW-1:0] W0   = {4'd4,  42'h123_4567};
    localparam logic [IW-1:0] W1   = {4'd5,  42'h3FF_FFFF_0001};
    localparam logic [IW-1:0] W2   = {4'd12, 42'h0AB};
    localparam logic [IW-1:0] W1B  = {4'd6,  42'h55};
    localparam logic [IW-1:0] JUNK = {4'd9,  42'h1};
    localparam logic [IW-1:0] ENDW = 46'h3000_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_valid = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          get_instr = 1'b0;
    logic [AW-1:0] get_instr_addr = '0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   fetch_count;
    logic          load_err;

    npu_instr_sequencer #(
        .OPCODE_WIDTH     (OW),
        .INSTR_WIDTH      (IW),
        .INSTR_MEM_AWIDTH (AW),
        .END_CHAIN_OP     (12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .prog_len       (prog_len),
        .get_instr      (get_instr),
        .get_instr_addr (get_instr_addr),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .busy           (busy),
        .done           (done),
        .fetch_count    (fetch_count),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run flag, a one-cycle completion flag and a memory image.
    logic [IW-1:0] m_mem [0:(1<<AW)-1];
    bit            m_run = 1'b0;
    bit            m_done = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_err = 1'b0;
    logic [IW-1:0] m_instr = '0;
    int            m_plen = 0;
    int            m_cnt = 0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run   = 1'b0;
            m_done  = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_instr = '0;
            m_cnt   = 0;
        end else begin
            bit was_done;
            bit ended;
            bit served;
            was_done = m_done;
            ended    = m_run && m_valid && (m_instr[IW-1 -: OW] == 4'd12);
            served   = m_run && get_instr && !ended;
            if (served) begin
                m_instr = (int'(get_instr_addr) < m_plen) ? m_mem[get_instr_addr] : ENDW;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            m_valid = served;
            if (load_valid) begin
                if (m_run) m_err = 1'b1;
                else m_mem[load_addr] = load_data;
            end
            m_done = ended;
            if (ended) begin
                m_run = 1'b0;
            end else if (start && !m_run && !was_done) begin
                m_run  = 1'b1;
                m_plen = int'(prog_len);
                m_cnt  = 0;
                m_err  = 1'b0;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("instruction", instruction, m_instr);
            check("instr_valid", instr_valid, m_valid);
            check("busy",        busy,        m_run);
            check("done",        done,        m_done);
            check("fetch_count", fetch_count, m_cnt);
            check("load_err",    load_err,    m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_run(input int plen);
        start    = 1'b1;
        prog_len = CW'(plen);
        tick();
        start = 1'b0;
    endtask

    task automatic fetch(input int a);
        get_instr      = 1'b1;
        get_instr_addr = AW'(a);
        tick();
    endtask

    task automatic idle_tick();
        get_instr = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst_instruction", instruction, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fetch_count, 0);
        tick();
        tick();
        rst = 1'b0;

        // Basic three-instruction program.
        load(0, W0);
        load(1, W1);
        load(2, W2);
        start_run(3);
        check("s1_busy", busy, 1);
        fetch(0);
        check("s1_w0", instruction, W0);
        check("s1_v0", instr_valid, 1);
        fetch(1);
        check("s1_w1", instruction, W1);
        fetch(2);
        check("s1_w2", instruction, W2);
        check("s1_done_early", done, 0);
        idle_tick();
        check("s1_done", done, 1);
        check("s1_busy_off", busy, 0);
        check("s1_count", fetch_count, 3);
        check("s1_hold", instruction, W2);
        tick();
        check("s1_done_pulse", done, 0);

        // Out-of-range fetch substitutes END_CHAIN.
        start_run(2);
        fetch(5);
        check("s2_end", instruction, ENDW);
        idle_tick();
        check("s2_done", done, 1);
        check("s2_count", fetch_count, 1);
        tick();

        // Load during RUN is dropped and flagged; fetch during END/DONE/IDLE ignored.
        start_run(3);
        load(0, JUNK);
        check("s3_err", load_err, 1);
        fetch(2);
        get_instr_addr = '0;
        tick();
        check("s3_drop_valid", instr_valid, 0);
        check("s3_drop_count", fetch_count, 1);
        tick();
        check("s3_doneget_valid", instr_valid, 0);
        check("s3_err_sticky", load_err, 1);
        tick();
        check("s3_idleget_valid", instr_valid, 0);
        check("s3_idleget_count", fetch_count, 1);
        get_instr = 1'b0;
        start_run(3);
        check("s3_err_clr", load_err, 0);
        fetch(0);
        check("s3_mem0_kept", instruction, W0);
        fetch(2);
        idle_tick();
        tick();

        // Reset mid-run aborts with no completion pulse.
        start_run(3);
        fetch(0);
        fetch(1);
        get_instr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("s5_instr0", instruction, 0);
        check("s5_valid0", instr_valid, 0);
        check("s5_busy0", busy, 0);
        check("s5_count0", fetch_count, 0);
        tick();
        rst = 1'b0;
        tick();
        check("s5_nodone", done, 0);
        start_run(3);
        fetch(0);
        check("s5_w0", instruction, W0);
        fetch(1);
        fetch(2);
        check("s5_w2", instruction, W2);
        idle_tick();
        check("s5_done", done, 1);
        check("s5_count", fetch_count, 3);
        tick();

        // Empty program; then simultaneous load+start and ignored start in RUN.
        start_run(0);
        fetch(0);
        check("s6_end", instruction, ENDW);
        idle_tick();
        check("s6_done", done, 1);
        tick();
        load_valid = 1'b1;
        load_addr  = 1;
        load_data  = W1B;
        start_run(3);
        load_valid = 1'b0;
        fetch(0);
        check("s6_w0", instruction, W0);
        get_instr = 1'b0;
        start_run(0);
        check("s6_start_ignored", fetch_count, 1);
        check("s6_still_busy", busy, 1);
        fetch(1);
        check("s6_new_w1", instruction, W1B);
        fetch(2);
        idle_tick();
        check("s6_done2", done, 1);
        check("s6_count", fetch_count, 3);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/npu_instr_sequencer.md
Name: npu_instr_sequencer

Overview:
- Instruction-memory front end that feeds the NPU's `instruction` input and answers its `get_instr`/`get_instr_addr` fetch requests.
- Host side preloads a program (sequence of INSTR_WIDTH words) and then issues a start pulse.
- The block serves fetches with fixed 1-cycle latency, substitutes END_CHAIN for out-of-range addresses, detects END_CHAIN issue to finish the run, and reports completion and statistics.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field; occupies instruction MSBs.
- INSTR_WIDTH, 46, instruction word width (4+6+10+6+10+10).
- INSTR_MEM_AWIDTH, 10, instruction-memory address width; depth = 2**INSTR_MEM_AWIDTH.
- END_CHAIN_OP, 12, opcode that terminates a program.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  host write strobe into instruction memory.
- load_addr  input  INSTR_MEM_AWIDTH  host write address.
- load_data  input  INSTR_WIDTH  host write data.
- start  input  1  one-cycle pulse that begins a run.
- prog_len  input  INSTR_MEM_AWIDTH+1  number of valid instructions; sampled on start.
- get_instr  input  1  NPU fetch request.
- get_instr_addr  input  INSTR_MEM_AWIDTH  NPU fetch address.
- instruction  output  INSTR_WIDTH  instruction to the NPU.
- instr_valid  output  1  `instruction` is valid this cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on run completion.
- fetch_count  output  INSTR_MEM_AWIDTH+1  number of fetches served in the last/current run; saturating.
- load_err  output  1  sticky; set when load_valid arrives while busy.

Behaviour:
- Reset (async, any state): state=IDLE; instruction=0, instr_valid=0, busy=0, done=0, fetch_count=0, load_err=0. Memory contents are not cleared.
- Memory: synchronous-write, synchronous-read single array, depth 2**INSTR_MEM_AWIDTH.
  - Writes are accepted only in IDLE or DONE.
  - load_valid in RUN: write dropped, load_err set. load_err clears only on reset or on start.
- States:
  - IDLE: start -> RUN; latch prog_len, clear fetch_count, clear load_err, busy=1 from the next cycle.
  - RUN: serve fetches as below. If the instruction driven out in this cycle has opcode==END_CHAIN_OP -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then -> IDLE. fetch_count holds its value until the next start.
- start in RUN or DONE is ignored.
- start with prog_len=0 enters RUN; the first fetch returns END_CHAIN.
- Fetch (RUN only):
  - get_instr high in cycle N -> instr_valid=1 in cycle N+1.
  - instruction in N+1 = mem[get_instr_addr] if get_instr_addr < latched prog_len; otherwise {END_CHAIN_OP, zeros}.
  - Back-to-back requests are served every cycle.
  - When get_instr is low: instr_valid=0 next cycle and instruction holds its last value.
  - get_instr outside RUN is ignored: instr_valid stays 0.
- fetch_count increments on each served fetch and saturates at its all-ones value.
- END_CHAIN detection uses instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH] on the output register. The END_CHAIN word itself is delivered (instr_valid=1) in the same cycle the state leaves RUN.
- A fetch request in the same cycle as the END_CHAIN delivery is dropped.
- Simultaneous load_valid and start in IDLE: the write commits; the run uses the new memory from its first fetch one cycle later.
- Reset mid-run aborts immediately; no done pulse.

Decomposition:
- Shared package npu_seq_pkg holds:
  - OPCODE_WIDTH, INSTR_WIDTH, INSTR_MEM_AWIDTH, END_CHAIN_OP constants, matching the NPU opcode defines.
  - state enum {IDLE, RUN, DONE}.
- One sub-module, instr_mem_sdp: simple-dual-port RAM with one write port and one registered read port, inferred as BRAM.

Test Plan:
- Load 3 words (addr0 opcode 4, addr1 opcode 5, addr2 opcode 12); start with prog_len=3; fetch addrs 0,1,2 on consecutive cycles -> words appear at N+1..N+3 with instr_valid=1; done pulses 1 cycle after addr2's word; fetch_count=3.
- Run with prog_len=2; fetch addr 5 -> instruction = 12<<42, state goes to DONE, done pulses.
- load_valid at addr0 during RUN -> load_err=1; mem[0] unchanged on the next run; next start clears load_err.
- get_instr in IDLE and in DONE -> instr_valid stays 0; fetch_count unchanged.
- Assert rst mid-run after 2 fetches -> all outputs 0 immediately; no done pulse; a fresh run then behaves as in the first scenario.
- start with prog_len=0, fetch addr 0 -> END_CHAIN returned, done pulses; a start pulse issued during RUN is ignored (fetch_count not cleared).
